fir_sched: RTL and testbench

//  Sequencer for the FIR engine. Owns the data SRAM as an 11-entry circular buffer, which replaces the shift register.
//  Per input sample: accepts one AXI-Stream word, writes it at the write pointer, then walks Tape_Num data/tap

---
 rtl/fir_sched.sv | 208 ++++++++++++++++++++
 tb/tb_fir_sched.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sched.sv
// fir_sched: sequencer for the FIR engine.
// It keeps the data SRAM as a circular buffer of the last Tape_Num samples and walks
// data/tap reads in lockstep to drive the MAC. It also runs the ap_start/ap_done
// handshake and the output-stream handshake.
// Optional feature: define FIR_SCHED_PERF_EN to add the cyc_cnt/stall_cnt performance counters.
module fir_sched #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   ap_start,
  output logic                   ap_idle,
  output logic                   ap_done,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  output logic [3:0]             data_WE,
  output logic                   data_EN,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic                   tap_EN,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic                   mac_clr,
  output logic                   mac_en,
  output logic                   sm_tvalid,
  output logic                   sm_tlast,
  input  logic                   sm_tready
`ifdef FIR_SCHED_PERF_EN
  ,
  output logic [31:0]            cyc_cnt,
  output logic [15:0]            stall_cnt
`endif
);

  localparam int unsigned IDX_W  = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(Tape_Num - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLR, ST_WAIT_IN, ST_WRITE, ST_READ, ST_DRAIN, ST_OUT, ST_DONE
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] k_q;
  logic [IDX_W-1:0] wp_q;
  logic             last_q;

  logic [IDX_W-1:0] k_d;
  logic [IDX_W-1:0] wp_d;
  logic [IDX_W-1:0] rd_idx_d;

  // (wp - k) mod Tape_Num: 5-bit subtract, add Tape_Num back when the borrow bit is set
  function automatic logic [IDX_W-1:0] ring_idx(input logic [IDX_W-1:0] wp,
                                                 input logic [IDX_W-1:0] k);
    logic [IDX_W:0] diff;
    diff = {1'b0, wp} - {1'b0, k};
    if (diff[IDX_W]) diff = diff + (IDX_W+1)'(Tape_Num);
    return diff[IDX_W-1:0];
  endfunction

  // Byte address of buffer entry idx
  function automatic logic [pADDR_WIDTH-1:0] byte_addr(input logic [IDX_W-1:0] idx);
    return pADDR_WIDTH'({idx, 2'b00});
  endfunction

  // Next tap index, next data read slot, and wrapped write pointer
  always_comb begin
    k_d      = k_q + IDX_W'(1);
    rd_idx_d = ring_idx(wp_q, k_d);
    wp_d     = (wp_q == LAST_IDX) ? '0 : wp_q + IDX_W'(1);
  end

  // Sequencer FSM; every output is registered with the value it holds in the next state
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      wp_q      <= '0;
      last_q    <= 1'b0;
      ap_idle   <= 1'b1;
      ap_done   <= 1'b0;
      ss_tready <= 1'b0;
      data_WE   <= '0;
      data_EN   <= 1'b0;
      data_Di   <= '0;
      data_A    <= '0;
      tap_EN    <= 1'b0;
      tap_A     <= '0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      sm_tvalid <= 1'b0;
      sm_tlast  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ap_start) begin
            state_q <= ST_CLR;
            k_q     <= '0;
            ap_idle <= 1'b0;
            data_EN <= 1'b1;
            data_WE <= 4'hF;
            data_Di <= '0;
            data_A  <= '0;
          end
        end
        ST_CLR: begin
          if (k_q == LAST_IDX) begin
            state_q   <= ST_WAIT_IN;
            wp_q      <= '0;
            data_EN   <= 1'b0;
            data_WE   <= '0;
            data_A    <= '0;
            ss_tready <= 1'b1;
          end else begin
            k_q    <= k_d;
            data_A <= byte_addr(k_d);
          end
        end
        ST_WAIT_IN: begin
          if (ss_tvalid) begin
            state_q   <= ST_WRITE;
            last_q    <= ss_tlast;
            ss_tready <= 1'b0;
            data_EN   <= 1'b1;
            data_WE   <= 4'hF;
            data_Di   <= ss_tdata;
            data_A    <= byte_addr(wp_q);
          end
        end
        ST_WRITE: begin
          state_q <= ST_READ;
          k_q     <= '0;
          data_WE <= '0;
          data_A  <= byte_addr(wp_q);
          tap_EN  <= 1'b1;
          tap_A   <= '0;
        end
        ST_READ: begin
          // Read data returns one cycle later, so MAC strobes trail the issued read
          mac_en  <= 1'b1;
          mac_clr <= (k_q == '0);
          if (k_q == LAST_IDX) begin
            state_q <= ST_DRAIN;
            data_EN <= 1'b0;
            tap_EN  <= 1'b0;
            data_A  <= '0;
            tap_A   <= '0;
          end else begin
            k_q    <= k_d;
            data_A <= byte_addr(rd_idx_d);
            tap_A  <= byte_addr(k_d);
          end
        end
        ST_DRAIN: begin
          state_q   <= ST_OUT;
          mac_en    <= 1'b0;
          mac_clr   <= 1'b0;
          sm_tvalid <= 1'b1;
          sm_tlast  <= last_q;
        end
        ST_OUT: begin
          if (sm_tready) begin
            sm_tvalid <= 1'b0;
            sm_tlast  <= 1'b0;
            wp_q      <= wp_d;
            if (last_q) begin
              state_q <= ST_DONE;
              ap_done <= 1'b1;
            end else begin
              state_q   <= ST_WAIT_IN;
              ss_tready <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ap_done <= 1'b0;
          ap_idle <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ap_idle <= 1'b1;
        end
      endcase
    end
  end

`ifdef FIR_SCHED_PERF_EN
  // Run-length and output-stall counters; cleared on an accepted start, held once idle
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
    end else if (state_q == ST_IDLE) begin
      if (ap_start) begin
        cyc_cnt   <= '0;
        stall_cnt <= '0;
      end
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (state_q == ST_OUT && !sm_tready) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_sched.sv
// Directed bench for fir_sched: clear phase, frame sequencing, ring-buffer addressing,
// output backpressure and mid-frame reset.
module tb_fir_sched;

  logic        axis_clk = 1'b0;
  logic        axis_rst = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_idle, ap_done;
  logic        ss_tvalid = 1'b0;
  logic [31:0] ss_tdata = '0;
  logic        ss_tlast = 1'b0;
  logic        ss_tready;
  logic [3:0]  data_WE;
  logic        data_EN;
  logic [31:0] data_Di;
  logic [11:0] data_A;
  logic        tap_EN;
  logic [11:0] tap_A;
  logic        mac_clr, mac_en;
  logic        sm_tvalid, sm_tlast;
  logic        sm_tready = 1'b0;
`ifdef FIR_SCHED_PERF_EN
  logic [31:0] cyc_cnt;
  logic [15:0] stall_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int wp_m   = 0;

  fir_sched dut (
    .axis_clk (axis_clk),
    .axis_rst (axis_rst),
    .ap_start (ap_start),
    .ap_idle  (ap_idle),
    .ap_done  (ap_done),
    .ss_tvalid(ss_tvalid),
    .ss_tdata (ss_tdata),
    .ss_tlast (ss_tlast),
    .ss_tready(ss_tready),
    .data_WE  (data_WE),
    .data_EN  (data_EN),
    .data_Di  (data_Di),
    .data_A   (data_A),
    .tap_EN   (tap_EN),
    .tap_A    (tap_A),
    .mac_clr  (mac_clr),
    .mac_en   (mac_en),
    .sm_tvalid(sm_tvalid),
    .sm_tlast (sm_tlast),
    .sm_tready(sm_tready)
`ifdef FIR_SCHED_PERF_EN
    ,
    .cyc_cnt  (cyc_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 axis_clk = ~axis_clk;

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse ap_start from IDLE and check the 11 clearing writes, ending in WAIT_IN
  task automatic do_start();
    chk("start_idle", 32'(ap_idle), 32'd1);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    chk("clr_idle_low", 32'(ap_idle), 32'd0);
    for (int i = 0; i < 11; i++) begin
      chk("clr_en", 32'(data_EN), 32'd1);
      chk("clr_we", 32'(data_WE), 32'hF);
      chk("clr_di", data_Di, 32'd0);
      chk("clr_addr", 32'(data_A), 32'(4 * i));
      chk("clr_tready", 32'(ss_tready), 32'd0);
      tick();
    end
    chk("wait_tready", 32'(ss_tready), 32'd1);
    chk("wait_en", 32'(data_EN), 32'd0);
    wp_m = 0;
  endtask

  // Push one sample from WAIT_IN through write, 11 reads, drain and output accept
  task automatic send_sample(input logic [31:0] d, input logic last, input int stall);
    chk("in_tready", 32'(ss_tready), 32'd1);
    ss_tvalid = 1'b1;
    ss_tdata  = d;
    ss_tlast  = last;
    tick();
    ss_tvalid = 1'b0;
    ss_tlast  = 1'b0;
    chk("wr_we", 32'(data_WE), 32'hF);
    chk("wr_en", 32'(data_EN), 32'd1);
    chk("wr_addr", 32'(data_A), 32'(4 * wp_m));
    chk("wr_di", data_Di, d);
    chk("wr_tready", 32'(ss_tready), 32'd0);
    tick();
    for (int k = 0; k < 11; k++) begin
      chk("rd_we", 32'(data_WE), 32'd0);
      chk("rd_en", 32'(data_EN & tap_EN), 32'd1);
      chk("rd_data_a", 32'(data_A), 32'(4 * ((wp_m - k + 11) % 11)));
      chk("rd_tap_a", 32'(tap_A), 32'(4 * k));
      chk("rd_mac_en", 32'(mac_en), (k > 0) ? 32'd1 : 32'd0);
      chk("rd_mac_clr", 32'(mac_clr), (k == 1) ? 32'd1 : 32'd0);
      if (k == 4) ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
    end
    chk("drain_mac_en", 32'(mac_en), 32'd1);
    chk("drain_mac_clr", 32'(mac_clr), 32'd0);
    chk("drain_tvalid", 32'(sm_tvalid), 32'd0);
    tick();
    chk("out_mac_en", 32'(mac_en), 32'd0);
    for (int s = 0; s < stall; s++) begin
      ss_tvalid = 1'b1;
      chk("stall_tvalid", 32'(sm_tvalid), 32'd1);
      chk("stall_tlast", 32'(sm_tlast), 32'(last));
      chk("stall_tready", 32'(ss_tready), 32'd0);
      tick();
    end
    ss_tvalid = 1'b0;
    chk("out_tvalid", 32'(sm_tvalid), 32'd1);
    chk("out_tlast", 32'(sm_tlast), 32'(last));
    chk("out_tready", 32'(ss_tready), 32'd0);
    sm_tready = 1'b1;
    tick();
    sm_tready = 1'b0;
    wp_m = (wp_m + 1) % 11;
    chk("acc_tvalid", 32'(sm_tvalid), 32'd0);
    if (last) begin
      chk("done_pulse", 32'(ap_done), 32'd1);
      chk("done_tready", 32'(ss_tready), 32'd0);
      tick();
      chk("done_clear", 32'(ap_done), 32'd0);
      chk("done_idle", 32'(ap_idle), 32'd1);
    end else begin
      chk("next_tready", 32'(ss_tready), 32'd1);
      chk("next_no_done", 32'(ap_done), 32'd0);
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_idle", 32'(ap_idle), 32'd1);
    chk("rst_tready", 32'(ss_tready), 32'd0);
    chk("rst_tvalid", 32'(sm_tvalid), 32'd0);
    chk("rst_data_en", 32'(data_EN), 32'd0);
    chk("rst_mac_en", 32'(mac_en), 32'd0);
    chk("rst_done", 32'(ap_done), 32'd0);
    axis_rst = 1'b0;
    tick();
    chk("idle_hold", 32'(ap_idle), 32'd1);

    // Three-sample frame
    do_start();
    send_sample(32'd1, 1'b0, 0);
    send_sample(32'd2, 1'b0, 0);
    send_sample(32'd3, 1'b1, 0);

    // Twelve samples: write pointer wraps to 0, one output held off for 5 cycles
    tick();
    do_start();
    for (int n = 1; n <= 12; n++)
      send_sample(32'(n * 16), (n == 12), (n == 2) ? 5 : 0);
`ifdef FIR_SCHED_PERF_EN
    chk("perf_stall", 32'(stall_cnt), 32'd5);
    chk("perf_cyc", cyc_cnt, 32'd197);
    tick();
    chk("perf_hold", 32'(stall_cnt), 32'd5);
`endif

    // Reset in the middle of READ aborts the frame without ap_done
    do_start();
    ss_tvalid = 1'b1;
    ss_tdata  = 32'hA5;
    tick();
    ss_tvalid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) tick();
    chk("mid_read_en", 32'(tap_EN), 32'd1);
    axis_rst = 1'b1;
    tick();
    axis_rst = 1'b0;
    chk("abort_idle", 32'(ap_idle), 32'd1);
    chk("abort_done", 32'(ap_done), 32'd0);
    chk("abort_data_en", 32'(data_EN), 32'd0);
    chk("abort_tap_en", 32'(tap_EN), 32'd0);
    chk("abort_mac_en", 32'(mac_en), 32'd0);
    chk("abort_tvalid", 32'(sm_tvalid), 32'd0);
    chk("abort_tready", 32'(ss_tready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", 32'(ap_done), 32'd0);
      chk("abort_stay_idle", 32'(ap_idle), 32'd1);
    end

    // Restart after abort clears the buffer again and completes a frame
    do_start();
    send_sample(32'd9, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
